// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-port ALU operation scheduler.
// Optional flags output is enabled with ALU_SCHED_FLAGS_EN.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: add, sub, compare, and.
// carry is meaningful only for add, borrow only for sub; both read 0 otherwise.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             borrow_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    y_o      = '0;
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_SUB: begin
        y_o      = a_i - b_i;
        borrow_o = (a_i < b_i);
      end
      // Compare packs {gt, lt, eq} into the low three bits.
      OP_CMP: y_o[2:0] = {(a_i > b_i), (a_i < b_i), (a_i == b_i)};
      default: y_o = a_i & b_i;
    endcase
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU between two requesters (IDLE -> EXEC -> DONE).
// Define ALU_SCHED_FLAGS_EN to add the registered res_flags {carry, borrow, zero} output.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
`ifdef ALU_SCHED_FLAGS_EN
  output logic [2:0]       res_flags,
`endif
  output logic             res_id
);

  sched_state_e     state_q, state_d;
  logic             last_grant_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] res_y_q;
  logic             res_id_q;

  logic             grant_vld;
  logic             grant_id;
  logic             take;

  logic [WIDTH-1:0] alu_y;
  logic             alu_carry, alu_borrow;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .y_o     (alu_y),
    .carry_o (alu_carry),
    .borrow_o(alu_borrow)
  );

  // With both ports valid the port that did not win last time gets the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    take       = (state_q == IDLE) && grant_vld;
    req0_ready = take && !grant_id;
    req1_ready = take && grant_id;
    res_valid  = (state_q == DONE);
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_y_q      <= '0;
      res_id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q         <= grant_id ? req1_op : req0_op;
        a_q          <= grant_id ? req1_a  : req0_a;
        b_q          <= grant_id ? req1_b  : req0_b;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        res_y_q  <= alu_y;
        res_id_q <= id_q;
      end
    end
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (state_q == EXEC) begin
      flags_q <= {alu_carry, alu_borrow, (alu_y == '0)};
    end
  end

  assign res_flags = flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = alu_carry ^ alu_borrow;
`endif

  assign res_y  = res_y_q;
  assign res_id = res_id_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed plus random bench for alu_op_scheduler against a transaction-level model.
// Define ALU_SCHED_FLAGS_EN to also check res_flags.
module tb_alu_op_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_y;
  logic       res_id;
`ifdef ALU_SCHED_FLAGS_EN
  logic [2:0] res_flags;
`endif

  int total = 0;
  int bad = 0;

  alu_op_scheduler #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
`ifdef ALU_SCHED_FLAGS_EN
    .res_flags (res_flags),
`endif
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a single slot that is busy for two cycles
  // after acceptance and then holds its result until consumed.
  int         m_busy;       // cycles left before result appears (0 = none pending)
  bit         m_holding;    // result presented and not yet consumed
  int         m_last;
  logic [3:0] m_y, pend_y;
  logic       m_id, pend_id;
  logic [2:0] m_flags, pend_flags;
  int         dut_grants[$];

  function automatic logic [3:0] ref_y(int op, int a, int b);
    int r;
    case (op)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = (a > b ? 4 : 0) + (a < b ? 2 : 0) + (a == b ? 1 : 0);
      default: r = a & b;
    endcase
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_flags(int op, int a, int b);
    logic c, bw, z;
    c  = (op == 0) && (a + b > 15);
    bw = (op == 1) && (a < b);
    z  = (ref_y(op, a, b) == 4'h0);
    return {c, bw, z};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_holding = 0; m_last = 1;
    m_y = '0; m_id = 1'b0; m_flags = '0;
    pend_y = '0; pend_id = 1'b0; pend_flags = '0;
  endtask

  task automatic reset_now();
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    dut_grants.delete();
    chk("rst_valid", res_valid, 0);
    chk("rst_y", res_y, 0);
    chk("rst_id", res_id, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
`ifdef ALU_SCHED_FLAGS_EN
    chk("rst_flags", res_flags, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the next rising edge will produce.
  task automatic step(input bit v0, input logic [1:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                      input bit v1, input logic [1:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                      input bit rr);
    int g;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    res_ready = rr;
    #1;
    g = -1;
    if (m_busy == 0 && !m_holding) begin
      if (v0 && v1) g = 1 - m_last;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("rdy0", req0_ready, (g == 0));
    chk("rdy1", req1_ready, (g == 1));
    chk("valid", res_valid, m_holding);
    chk("y", res_y, m_y);
    chk("id", res_id, m_id);
`ifdef ALU_SCHED_FLAGS_EN
    chk("flags", res_flags, m_flags);
`endif
    if (req0_ready) dut_grants.push_back(0);
    if (req1_ready) dut_grants.push_back(1);
    if (m_holding) begin
      if (rr) m_holding = 0;
    end else if (m_busy == 1) begin
      m_busy = 0; m_holding = 1;
      m_y = pend_y; m_id = pend_id; m_flags = pend_flags;
    end else if (g >= 0) begin
      m_last = g; m_busy = 1;
      pend_id = g[0];
      pend_y = (g == 0) ? ref_y(o0, a0, b0) : ref_y(o1, a1, b1);
      pend_flags = (g == 0) ? ref_flags(o0, a0, b0) : ref_flags(o1, a1, b1);
    end
  endtask

  task automatic idle(input bit rr);
    step(0, 2'd0, 4'h0, 4'h0, 0, 2'd0, 4'h0, 4'h0, rr);
  endtask

  // Single-port operation; checks the result while it is presented.
  task automatic single(input bit port, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_y, input string tag);
    if (port) step(0, 2'd0, 4'h0, 4'h0, 1, op, a, b, 0);
    else      step(1, op, a, b, 0, 2'd0, 4'h0, 4'h0, 0);
    idle(0);
    idle(0);
    chk(tag, res_y, exp_y);
    chk({tag, "_id"}, res_id, port);
    idle(1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    reset_now();

    // add 7+9 on port 0
    step(1, 2'd0, 4'h7, 4'h9, 0, 2'd0, 4'h0, 4'h0, 0);
    chk("add_rdy0", req0_ready, 1);
    idle(0);
    idle(0);
    chk("add_y", res_y, 4'h0);
    chk("add_id", res_id, 0);
    chk("add_valid", res_valid, 1);
`ifdef ALU_SCHED_FLAGS_EN
    chk("add_flags", res_flags, 3'b101);
`endif
    idle(1);

    // both ports valid continuously, alternating grants
    reset_now();
    for (int unsigned i = 0; i < 12; i++) begin
      step(1, 2'd0, 4'h1, 4'h2, 1, 2'd1, 4'h3, 4'h5, 1);
      if (i == 5) begin
        chk("sub_y", res_y, 4'hE);
        chk("sub_id", res_id, 1);
`ifdef ALU_SCHED_FLAGS_EN
        chk("sub_flags", res_flags, 3'b010);
`endif
      end
    end
    chk("grant_count", dut_grants.size(), 4);
    for (int unsigned i = 0; i < 4 && i < dut_grants.size(); i++)
      chk("grant_order", dut_grants[i], i % 2);

    // compare and and
    single(0, 2'd2, 4'h5, 4'h5, 4'b0001, "cmp_eq");
    single(1, 2'd2, 4'h9, 4'h2, 4'b0100, "cmp_gt");
    single(0, 2'd3, 4'hC, 4'hA, 4'h8, "and");

    // result held 5 cycles while both ports wait, then port 1 drops before grant
    step(1, 2'd3, 4'hF, 4'h6, 0, 2'd0, 4'h0, 4'h0, 0);
    idle(0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(1, 2'd0, 4'h1, 4'h1, 1, 2'd0, 4'h2, 4'h2, 0);
      chk("hold_y", res_y, 4'h6);
      chk("hold_rdy0", req0_ready, 0);
    end
    step(0, 2'd0, 4'h0, 4'h0, 1, 2'd0, 4'h2, 4'h2, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      idle(0);
      chk("drop_valid", res_valid, 0);
      chk("drop_rdy1", req1_ready, 0);
    end

    // reset during EXEC, then a contested grant goes to port 0
    step(0, 2'd0, 4'h0, 4'h0, 1, 2'd0, 4'h4, 4'h4, 0);
    @(posedge clk);
    #2;
    reset_now();
    step(1, 2'd0, 4'h2, 4'h3, 1, 2'd0, 4'h4, 4'h4, 0);
    chk("post_rst_grant0", req0_ready, 1);
    idle(0);
    idle(0);
    chk("post_rst_y", res_y, 4'h5);

    // reset while a result is presented drops res_valid at once
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_valid", res_valid, 0);
    reset_now();

    // random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 2'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 1), 2'($urandom), 4'($urandom), 4'($urandom),
           ($urandom % 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
